// File: rtl/generador_de_tono_if.sv
// Load/observe bundle of the tone synthesizer: the sequencer drives a frequency
// and a load strobe, the synthesizer reports idle, the buzzer pin and the half-period.
interface generador_de_tono_if #(
  parameter int FREQ_W = 10,
  parameter int Q_W    = 25
);
  logic [FREQ_W-1:0] frecuencia;
  logic              cargar;
  logic              listo;
  logic              buzzer;
  logic [Q_W-1:0]    semiperiodo;

  modport master (output frecuencia, cargar, input listo, buzzer, semiperiodo);
  modport slave  (input frecuencia, cargar, output listo, buzzer, semiperiodo);
endinterface

// File: rtl/generador_de_tono.sv
// Square-wave tone synthesizer: serial restoring divider turns Hz into a half-period,
// and a toggle counter plays it; new half-periods are swapped in only at a toggle.
module generador_de_tono #(
  parameter int CLK_HZ = 50_000_000,
  parameter int FREQ_W = 10,
  parameter int Q_W    = 25
) (
  input  logic              clk,
  input  logic              rst,
  generador_de_tono_if.slave tono
);
  typedef enum logic [1:0] {REPOSO, DIVIDIR, PENDIENTE} estado_t;

  localparam int             PW        = $clog2(Q_W);
  localparam logic [Q_W-1:0] DIVIDENDO = Q_W'(CLK_HZ / 2);

  estado_t           estado;
  logic [Q_W:0]      resto;
  logic [Q_W-1:0]    dividendo, cociente, pendiente, contador, semi;
  logic [FREQ_W-1:0] divisor;
  logic [PW-1:0]     paso;
  logic              listo, buzzer;

  logic [Q_W:0]      resto_sh, resto_nx;
  logic [Q_W-1:0]    cociente_nx, q_final;
  logic              ajuste, vuelta;

  // One restoring-division iteration, MSB of the dividend shifted in first.
  always_comb begin
    resto_sh    = {resto[Q_W-1:0], dividendo[Q_W-1]};
    ajuste      = resto_sh >= (Q_W+1)'(divisor);
    resto_nx    = ajuste ? resto_sh - (Q_W+1)'(divisor) : resto_sh;
    cociente_nx = {cociente[Q_W-2:0], ajuste};
    q_final     = (cociente_nx == '0) ? Q_W'(1) : cociente_nx;
    vuelta      = (semi != '0) && (contador == semi - Q_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado    <= REPOSO;
      listo     <= 1'b1;
      buzzer    <= 1'b0;
      semi      <= '0;
      contador  <= '0;
      resto     <= '0;
      dividendo <= '0;
      cociente  <= '0;
      pendiente <= '0;
      divisor   <= '0;
      paso      <= '0;
    end else begin
      if (semi != '0) begin
        if (vuelta) begin
          contador <= '0;
          buzzer   <= ~buzzer;
        end else begin
          contador <= contador + Q_W'(1);
        end
      end

      case (estado)
        REPOSO: if (tono.cargar) begin
          if (tono.frecuencia == '0) begin
            semi     <= '0;
            contador <= '0;
            buzzer   <= 1'b0;
          end else begin
            divisor   <= tono.frecuencia;
            dividendo <= DIVIDENDO;
            resto     <= '0;
            cociente  <= '0;
            paso      <= PW'(Q_W - 1);
            estado    <= DIVIDIR;
            listo     <= 1'b0;
          end
        end
        DIVIDIR: begin
          resto     <= resto_nx;
          cociente  <= cociente_nx;
          dividendo <= dividendo << 1;
          paso      <= paso - PW'(1);
          if (paso == '0) begin
            // From silence there is no phase to preserve, so apply at once.
            if (semi == '0) begin
              semi     <= q_final;
              contador <= '0;
              estado   <= REPOSO;
              listo    <= 1'b1;
            end else begin
              pendiente <= q_final;
              estado    <= PENDIENTE;
            end
          end
        end
        PENDIENTE: if (vuelta) begin
          semi     <= pendiente;
          contador <= '0;
          estado   <= REPOSO;
          listo    <= 1'b1;
        end
        default: begin
          estado <= REPOSO;
          listo  <= 1'b1;
        end
      endcase
    end
  end

  assign tono.listo       = listo;
  assign tono.buzzer      = buzzer;
  assign tono.semiperiodo = semi;
endmodule

// File: tb/tb_generador_de_tono.sv
// Bench for generador_de_tono: a 100 kHz instance for the main plan plus a 1 kHz
// instance sharing the same load bus for the forced-Q=1 corner.
module tb_generador_de_tono;
  localparam int FW = 10;
  localparam int QW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  generador_de_tono_if #(.FREQ_W(FW), .Q_W(QW)) bus ();
  generador_de_tono_if #(.FREQ_W(FW), .Q_W(QW)) bus_l ();
  assign bus_l.frecuencia = bus.frecuencia;
  assign bus_l.cargar     = bus.cargar;

  generador_de_tono #(.CLK_HZ(100_000), .FREQ_W(FW), .Q_W(QW)) dut (
    .clk(clk), .rst(rst), .tono(bus));
  generador_de_tono #(.CLK_HZ(1000), .FREQ_W(FW), .Q_W(QW)) dut_l (
    .clk(clk), .rst(rst), .tono(bus_l));

  typedef struct {int f; int semi; int lat;} vec_t;
  vec_t tabla[6];

  int   errores = 0;
  int   checks  = 0;
  int   cyc     = 0;
  int   t_last  = -1;
  logic prev_buz = 1'b0;
  int   hp_q[$];

  // Reference: half-period is floor((CLK_HZ/2)/f), at least 1; 0 Hz is silence.
  function automatic longint q_ref(longint clk_hz, longint f);
    longint q;
    if (f == 0) return 0;
    q = (clk_hz / 2) / f;
    return (q == 0) ? 1 : q;
  endfunction

  function automatic int cuenta_fuera(int a, int b);
    int n = 0;
    foreach (hp_q[i]) if (hp_q[i] != a && hp_q[i] != b) n++;
    return n;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errores++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance one cycle, sample after the edge and log buzzer half-period lengths.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (bus.buzzer !== prev_buz) begin
      if (t_last >= 0) hp_q.push_back(cyc - t_last);
      t_last   = cyc;
      prev_buz = bus.buzzer;
    end
  endtask

  task automatic clr_mon();
    hp_q.delete();
    t_last   = -1;
    prev_buz = bus.buzzer;
  endtask

  task automatic do_reset();
    bus.cargar = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic cargar_nota(input int f, output int lat);
    bus.frecuencia = FW'(f);
    bus.cargar     = 1'b1;
    tick();
    bus.cargar = 1'b0;
    lat = 1;
    while (!bus.listo && lat < 70000) begin tick(); lat++; end
    chk("listo_tras_carga", bus.listo, 1);
  endtask

  task automatic esperar_flanco(output int n);
    logic b;
    b = bus.buzzer;
    n = 0;
    do begin tick(); n++; end while (bus.buzzer === b && n < 70000);
  endtask

  initial begin
    int lat, n, f;
    bus.frecuencia = '0;
    bus.cargar     = 1'b0;

    tabla[0] = '{f: 440,  semi: 113,   lat: 17};
    tabla[1] = '{f: 1000, semi: 50,    lat: 17};
    tabla[2] = '{f: 1,    semi: 50000, lat: 17};
    tabla[3] = '{f: 1023, semi: 48,    lat: 17};
    tabla[4] = '{f: 262,  semi: 190,   lat: 17};
    tabla[5] = '{f: 0,    semi: 0,     lat: 1};

    do_reset();
    chk("reset_listo", bus.listo, 1);
    chk("reset_buzzer", bus.buzzer, 0);
    chk("reset_semi", bus.semiperiodo, 0);
    chk("reset_semi_l", bus_l.semiperiodo, 0);

    foreach (tabla[i]) begin
      do_reset();
      cargar_nota(tabla[i].f, lat);
      chk($sformatf("tab%0d_lat", i), lat, tabla[i].lat);
      chk($sformatf("tab%0d_semi", i), bus.semiperiodo, tabla[i].semi);
      chk($sformatf("tab%0d_semi_l", i), bus_l.semiperiodo, q_ref(1000, tabla[i].f));
      chk($sformatf("tab%0d_buzzer", i), bus.buzzer, 0);
    end

    // 440 Hz from silence: first rise, then exact 113/113 duty.
    do_reset();
    cargar_nota(440, lat);
    esperar_flanco(n);
    chk("p440_primera_subida", n, 113);
    clr_mon();
    repeat (460) tick();
    chk("p440_n_semis", hp_q.size() >= 3, 1);
    chk("p440_duty", cuenta_fuera(113, 113), 0);

    // Glitch-free swap to 1000 Hz.
    clr_mon();
    cargar_nota(1000, lat);
    chk("p1000_lat_rango", (lat >= 17 && lat <= 130), 1);
    chk("p1000_semi", bus.semiperiodo, 50);
    repeat (400) tick();
    chk("p1000_sin_glitch", cuenta_fuera(113, 50), 0);
    chk("p1000_ultimo", hp_q[$], 50);
    chk("p1000_penultimo", hp_q[hp_q.size()-2], 50);

    // Reloading the same frequency keeps phase.
    clr_mon();
    cargar_nota(1000, lat);
    chk("recarga_lat", (lat >= 17 && lat <= 67), 1);
    repeat (300) tick();
    chk("recarga_fase", cuenta_fuera(50, 50), 0);

    // Silence request.
    cargar_nota(0, lat);
    chk("silencio_lat", lat, 1);
    chk("silencio_buzzer", bus.buzzer, 0);
    chk("silencio_semi", bus.semiperiodo, 0);
    n = 0;
    repeat (1000) begin tick(); if (bus.buzzer !== 1'b0) n++; end
    chk("silencio_mantenido", n, 0);

    // Load pulsed during DIVIDIR is ignored.
    do_reset();
    bus.frecuencia = FW'(440);
    bus.cargar = 1'b1;
    tick();
    bus.cargar = 1'b0;
    lat = 1;
    repeat (4) begin tick(); lat++; end
    bus.frecuencia = FW'(262);
    bus.cargar = 1'b1;
    tick(); lat++;
    bus.cargar = 1'b0;
    while (!bus.listo && lat < 1000) begin tick(); lat++; end
    chk("ignorada_lat", lat, 17);
    chk("ignorada_semi", bus.semiperiodo, 113);
    n = 0;
    repeat (20) begin tick(); if (bus.listo !== 1'b1) n++; end
    chk("ignorada_sin_division", n, 0);
    chk("ignorada_semi_fin", bus.semiperiodo, 113);

    // Reset mid-DIVIDIR while a tone is playing.
    repeat (30) tick();
    bus.frecuencia = FW'(1000);
    bus.cargar = 1'b1;
    tick();
    bus.cargar = 1'b0;
    repeat (5) tick();
    chk("rst_div_ocupado", bus.listo, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_div_listo", bus.listo, 1);
    chk("rst_div_buzzer", bus.buzzer, 0);
    chk("rst_div_semi", bus.semiperiodo, 0);
    cargar_nota(440, lat);
    chk("rst_div_recarga_lat", lat, 17);
    chk("rst_div_recarga_semi", bus.semiperiodo, 113);

    // Reset in PENDIENTE: toggle is ~86 cycles away when reset hits.
    esperar_flanco(n);
    bus.frecuencia = FW'(1000);
    bus.cargar = 1'b1;
    tick();
    bus.cargar = 1'b0;
    repeat (26) tick();
    chk("rst_pend_ocupado", bus.listo, 0);
    chk("rst_pend_semi_viejo", bus.semiperiodo, 113);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_pend_listo", bus.listo, 1);
    chk("rst_pend_buzzer", bus.buzzer, 0);
    chk("rst_pend_semi", bus.semiperiodo, 0);
    repeat (300) tick();
    chk("rst_pend_descartado", bus.semiperiodo, 0);
    cargar_nota(440, lat);
    chk("rst_pend_recarga_lat", lat, 17);
    chk("rst_pend_recarga_semi", bus.semiperiodo, 113);

    // 1 kHz instance: Q=0 forced to 1, buzzer toggles every cycle.
    do_reset();
    cargar_nota(1023, lat);
    chk("lento_semi", bus_l.semiperiodo, 1);
    n = 0;
    repeat (8) begin
      logic b;
      b = bus_l.buzzer;
      tick();
      if (bus_l.buzzer !== b) n++;
    end
    chk("lento_toggle", n, 8);

    // Random frequencies from silence against the reference.
    repeat (12) begin
      f = $urandom_range(20, 1023);
      do_reset();
      cargar_nota(f, lat);
      chk($sformatf("rnd_f%0d_lat", f), lat, 17);
      chk($sformatf("rnd_f%0d_semi", f), bus.semiperiodo, q_ref(100_000, f));
      chk($sformatf("rnd_f%0d_semi_l", f), bus_l.semiperiodo, q_ref(1000, f));
      esperar_flanco(n);
      chk($sformatf("rnd_f%0d_subida", f), n, q_ref(100_000, f));
      esperar_flanco(n);
      chk($sformatf("rnd_f%0d_semi_alto", f), n, q_ref(100_000, f));
    end

    $display("Result: errors=%0d of %0d checks", errores, checks);
    $finish;
  end
endmodule

// File: doc/generador_de_tono.md
# generador_de_tono

Tone synthesizer that converts a note frequency in Hz into a square wave on a buzzer pin. It consumes the `frecuencia` stream produced by the melody sequencer. On each load strobe it computes the half-period in clock cycles with a serial restoring divider, then drives a 50 % duty square wave. Frequency changes are applied glitch-free at a toggle boundary, and a frequency of 0 means silence.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz; must be even, and CLK_HZ/2 < 2^Q_W.
- `FREQ_W`, default 10: width of the frequency input in Hz.
- `Q_W`, default 25: width of the quotient, half-period register and counter; also the number of divider iterations.
- `clk` input, 1 bit: single system clock, rising edge.
- `rst` input, 1 bit: synchronous reset, active-high.
- `frecuencia` input, FREQ_W bits: requested tone in Hz; 0 means silence.
- `cargar` input, 1 bit: load strobe; sampled only while `listo`=1.
- `listo` output, 1 bit: block is idle and will accept `cargar`.
- `buzzer` output, 1 bit: square wave output, registered.
- `semiperiodo` output, Q_W bits: half-period currently in effect, in clock cycles; 0 means silent.

## Operation
- States:
  - REPOSO: `listo`=1.
  - DIVIDIR: Q_W cycles, `listo`=0.
  - PENDIENTE: waiting to apply the result, `listo`=0.
- Reset values: state REPOSO, `listo`=1, `buzzer`=0, `semiperiodo`=0, counter 0, divider registers 0.
- Reset asserted in any state, including mid-division or PENDIENTE, aborts the operation and discards the pending result.
- REPOSO + `cargar`=1, `frecuencia`=0:
  - Next cycle: `semiperiodo`=0, `buzzer`=0, counter=0.
  - State stays REPOSO.
- REPOSO + `cargar`=1, `frecuencia`≠0:
  - Latch the divisor D=`frecuencia` and the dividend N=CLK_HZ/2.
  - Go to DIVIDIR.
- DIVIDIR runs a restoring division, one quotient bit per cycle, MSB first:
  - Remainder width is Q_W+1 bits.
  - Each iteration: shift the remainder left, bringing in the next bit of N. If remainder ≥ D, subtract D and set the quotient bit to 1.
  - After Q_W iterations, Q = floor(N/D).
  - If Q=0, it is forced to 1.
- Leaving DIVIDIR:
  - If `semiperiodo`=0 (currently silent): load `semiperiodo`=Q, clear the counter, keep `buzzer`=0, go to REPOSO.
  - Otherwise: store Q as pending and go to PENDIENTE.
- PENDIENTE:
  - On the cycle the tone counter wraps (the toggle event), load `semiperiodo`=Q and clear the counter.
  - The new half-period governs the very next half-cycle.
  - Go to REPOSO.
- Tone counter, active whenever `semiperiodo`≠0:
  - If counter = `semiperiodo`−1: counter←0 and `buzzer` toggles.
  - Otherwise: counter increments.
  - Output period is 2·`semiperiodo` cycles.
- While `semiperiodo`=0, the counter holds 0 and `buzzer` holds 0.
- The tone keeps running with the old half-period throughout DIVIDIR and PENDIENTE.
- `cargar` while `listo`=0 is ignored. The `frecuencia` value is not captured.
- Reloading the same frequency produces no phase discontinuity, because the change is applied only at a toggle.

## Timing
- `cargar` is sampled at cycle 0.
- DIVIDIR spans cycles 1..Q_W.
- From silence: `semiperiodo` is valid and `listo`=1 at cycle Q_W+1. The first `buzzer` rise occurs Q cycles later.
- From an active tone: the change is applied at the first toggle at or after cycle Q_W+1. `listo` returns high the cycle after that toggle. Worst case is Q_W + old `semiperiodo` + 1 cycles.
- Silence request: `buzzer`=0 and `semiperiodo`=0 at cycle 1, and `listo` stays 1.
- `cargar` held high in REPOSO restarts an operation each time `listo` is seen high; a caller should pulse it for 1 cycle.
- Width rules:
  - Remainder comparison is unsigned on Q_W+1 bits.
  - The divisor is zero-extended from FREQ_W bits.
  - The counter is Q_W bits, and never exceeds `semiperiodo`−1.

## Test plan
- **Silence to 440 Hz.** Use CLK_HZ=100_000, Q_W=16, and pulse `cargar` with `frecuencia`=440.
  - `listo` is 0 for 16 cycles, then 1.
  - `semiperiodo`=113.
  - `buzzer` period is 226 cycles with exact 113/113 duty.
- **Glitch-free change.** While playing 440, load 1000 (Q=50).
  - Old 113-cycle half-periods continue until a toggle.
  - No half-period shorter than 50 or longer than 113 appears.
  - After the swap, the period is 100 cycles.
- **Silence request.** While playing, load 0.
  - Next cycle `buzzer`=0 and `semiperiodo`=0.
  - `buzzer` stays 0 for ≥1000 cycles.
- **Ignored load.** Pulse `cargar` with 262 during DIVIDIR.
  - The result still reflects the original frequency.
  - No extra division starts.
- **Boundary values.**
  - `frecuencia`=1 gives `semiperiodo`=50000.
  - `frecuencia`=1023 gives `semiperiodo`=48.
  - With CLK_HZ=1000, `frecuencia`=1023 gives a computed Q=0, forced to 1; `buzzer` toggles every cycle.
- **Reset mid-operation.**
  - Assert `rst` during DIVIDIR and separately during PENDIENTE.
  - Next cycle: `listo`=1, `buzzer`=0, `semiperiodo`=0.
  - A subsequent load of 440 again yields 113.
